// File: rtl/knight_pkg.sv
// Shared types and constants for the KnightsTour command/motion path.
package knight_pkg;

  typedef enum logic [3:0] {
    OpCal     = 4'h0,
    OpMove    = 4'h2,
    OpMoveFan = 4'h3,
    OpTour    = 4'h4
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StCal,
    StTurn,
    StRampUp,
    StRampDn
  } state_e;

  localparam logic [9:0] FRWRD_MAX = 10'h300;
  localparam logic [7:0] RESP_ACK  = 8'hA5;

  // A zero heading field means North; otherwise the low nibble is filled with 1s.
  function automatic logic [11:0] desired_hdg(input logic [7:0] hdg);
    return (hdg != 8'h00) ? {hdg, 4'hF} : 12'h000;
  endfunction

endpackage

// File: rtl/cntr_strip_det.sv
// Centre-strip IR crossing counter: synchroniser, rising-edge detect, 4-bit saturating count.
module cntr_strip_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       cntrIR,
  output logic [3:0] cnt
);

  logic ir_ff1_q, ir_ff2_q, ir_prev_q;
  logic rise;
  logic [3:0] cnt_q, cnt_d;

  assign rise = ir_ff2_q & ~ir_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'h0;
    end else if (en && rise && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'h1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_ff1_q  <= 1'b0;
      ir_ff2_q  <= 1'b0;
      ir_prev_q <= 1'b0;
      cnt_q     <= 4'h0;
    end else begin
      ir_ff1_q  <= cntrIR;
      ir_ff2_q  <= ir_ff1_q;
      ir_prev_q <= ir_ff2_q;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/move_cmd_proc.sv
// Command processor: decodes remote commands and sequences turn / ramp-up / ramp-down moves.
module move_cmd_proc
  import knight_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b1,
  parameter logic [11:0] ERR_THRESH = 12'h02C,
  parameter logic [11:0] NUDGE      = 12'h05F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        lftIR,
  input  logic        cntrIR,
  input  logic        rghtIR,
  output logic [11:0] error,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        tour_go,
  output logic        fanfare_go
);

  localparam logic [9:0] Step   = FAST_SIM ? 10'h020 : 10'h003;
  localparam logic [9:0] StepDn = {Step[8:0], 1'b0};

  state_e      state_q, state_d;
  logic [15:0] cmd_q;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] error_q, error_d;
  logic        moving_q, moving_d;
  logic        send_resp_q, send_resp_d;
  logic        strt_cal_q, strt_cal_d;
  logic        tour_go_q, tour_go_d;
  logic        fanfare_go_q, fanfare_go_d;

  logic        capture;
  logic        strip_clr;
  logic [3:0]  strip_cnt;
  logic        strip_hit;
  logic [11:0] nudge;
  logic [11:0] err_mag;
  logic        err_small;
  logic [10:0] frwrd_sum;
  logic [9:0]  frwrd_up, frwrd_dn;

  assign capture     = (state_q == StIdle) && cmd_rdy;
  assign clr_cmd_rdy = capture;

  cntr_strip_det u_strip (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (strip_clr),
    .en     (state_q == StRampUp),
    .cntrIR (cntrIR),
    .cnt    (strip_cnt)
  );

  assign strip_hit = ({1'b0, strip_cnt} == {cmd_q[3:0], 1'b0});

  // Side-IR correction only matters while the robot is actually driving forward.
  always_comb begin
    nudge = 12'h000;
    if (frwrd_q != 10'h000) begin
      if (lftIR && !rghtIR) begin
        nudge = NUDGE;
      end else if (rghtIR && !lftIR) begin
        nudge = 12'h000 - NUDGE;
      end
    end
  end

  assign error_d   = heading - desired_hdg(cmd_q[11:4]) + nudge;
  assign err_mag   = error_q[11] ? (~error_q + 12'h001) : error_q;
  assign err_small = (err_mag < ERR_THRESH);

  assign frwrd_sum = {1'b0, frwrd_q} + {1'b0, Step};
  assign frwrd_up  = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[9:0];
  assign frwrd_dn  = (frwrd_q > StepDn) ? (frwrd_q - StepDn) : 10'h000;

  always_comb begin
    state_d      = state_q;
    frwrd_d      = frwrd_q;
    moving_d     = moving_q;
    send_resp_d  = 1'b0;
    strt_cal_d   = 1'b0;
    tour_go_d    = 1'b0;
    fanfare_go_d = 1'b0;
    strip_clr    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_rdy) begin
          case (cmd[15:12])
            OpCal: begin
              strt_cal_d = 1'b1;
              state_d    = StCal;
            end
            OpMove, OpMoveFan: begin
              frwrd_d   = 10'h000;
              moving_d  = 1'b1;
              strip_clr = 1'b1;
              state_d   = StTurn;
            end
            OpTour:  tour_go_d = 1'b1;
            default: ;
          endcase
        end
      end
      StCal: begin
        if (cal_done) begin
          send_resp_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StTurn: begin
        if (heading_rdy && err_small) begin
          state_d = StRampUp;
        end
      end
      StRampUp: begin
        // Speed update and target check are independent so both take effect together.
        if (heading_rdy) begin
          frwrd_d = frwrd_up;
        end
        if (strip_hit) begin
          state_d = StRampDn;
        end
      end
      StRampDn: begin
        if (frwrd_q == 10'h000) begin
          moving_d     = 1'b0;
          send_resp_d  = 1'b1;
          fanfare_go_d = (cmd_q[15:12] == OpMoveFan);
          state_d      = StIdle;
        end else if (heading_rdy) begin
          frwrd_d = frwrd_dn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmd_q        <= 16'h0000;
      frwrd_q      <= 10'h000;
      error_q      <= 12'h000;
      moving_q     <= 1'b0;
      send_resp_q  <= 1'b0;
      strt_cal_q   <= 1'b0;
      tour_go_q    <= 1'b0;
      fanfare_go_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frwrd_q      <= frwrd_d;
      error_q      <= error_d;
      moving_q     <= moving_d;
      send_resp_q  <= send_resp_d;
      strt_cal_q   <= strt_cal_d;
      tour_go_q    <= tour_go_d;
      fanfare_go_q <= fanfare_go_d;
      if (capture) begin
        cmd_q <= cmd;
      end
    end
  end

  assign send_resp  = send_resp_q;
  assign strt_cal   = strt_cal_q;
  assign error      = error_q;
  assign frwrd      = frwrd_q;
  assign moving     = moving_q;
  assign tour_go    = tour_go_q;
  assign fanfare_go = fanfare_go_q;

endmodule

// File: tb/tb_move_cmd_proc.sv
// Directed self-checking bench for move_cmd_proc.
module tb_move_cmd_proc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        strt_cal;
  logic        cal_done;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        lftIR, cntrIR, rghtIR;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        moving;
  logic        tour_go;
  logic        fanfare_go;

  int checks = 0;
  int errors = 0;

  move_cmd_proc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .strt_cal    (strt_cal),
    .cal_done    (cal_done),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .lftIR       (lftIR),
    .cntrIR      (cntrIR),
    .rghtIR      (rghtIR),
    .error       (error),
    .frwrd       (frwrd),
    .moving      (moving),
    .tour_go     (tour_go),
    .fanfare_go  (fanfare_go)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    cmd     = c;
    cmd_rdy = 1'b1;
    #1;
    chk("clr_cmd_rdy_hi", clr_cmd_rdy, 16'h1);
    @(negedge clk);
    cmd_rdy = 1'b0;
    #1;
    chk("clr_cmd_rdy_lo", clr_cmd_rdy, 16'h0);
  endtask

  task automatic hr_pulse();
    heading_rdy = 1'b1;
    @(negedge clk);
    heading_rdy = 1'b0;
  endtask

  task automatic cntr_pulse();
    cntrIR = 1'b1;
    tick(3);
    cntrIR = 1'b0;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; cmd = 16'h0000; cmd_rdy = 1'b0; cal_done = 1'b0;
    heading = 12'h000; heading_rdy = 1'b0;
    lftIR = 1'b0; cntrIR = 1'b0; rghtIR = 1'b0;
    tick(2);
    chk("rst_frwrd", frwrd, 16'h0);
    chk("rst_moving", moving, 16'h0);
    chk("rst_error", error, 16'h0);
    chk("rst_pulses", {send_resp, strt_cal, tour_go, fanfare_go, clr_cmd_rdy}, 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Calibrate
    send_cmd(16'h0000);
    chk("cal_strt", strt_cal, 16'h1);
    chk("cal_tour", tour_go, 16'h0);
    tick();
    chk("cal_strt_end", strt_cal, 16'h0);
    tick(48);
    chk("cal_no_resp", send_resp, 16'h0);
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    chk("cal_resp", send_resp, 16'h1);
    tick();
    chk("cal_resp_end", send_resp, 16'h0);

    // Move 0x3F heading, 1 square, no fanfare
    send_cmd(16'h23F1);
    chk("mv_moving", moving, 16'h1);
    chk("mv_frwrd0", frwrd, 16'h0);
    tick();
    chk("mv_err", error, 16'hC01);
    hr_pulse();                  // error too large: stays in TURN
    heading = 12'h3F0;
    tick();
    chk("mv_err_near", error, 16'hFF1);
    hr_pulse();                  // enters RAMP_UP, frwrd still 0
    chk("mv_turn_frwrd", frwrd, 16'h0);
    hr_pulse();
    chk("mv_ramp1", frwrd, 16'h020);
    repeat (23) hr_pulse();
    chk("mv_ramp_max", frwrd, 16'h300);
    hr_pulse();
    chk("mv_ramp_sat", frwrd, 16'h300);

    // Side IR nudges
    heading = 12'h3FF;
    lftIR = 1'b1;
    tick();
    chk("nudge_lft", error, 16'h05F);
    rghtIR = 1'b1;
    tick();
    chk("nudge_both", error, 16'h000);
    lftIR = 1'b0;
    tick();
    chk("nudge_rght", error, 16'hFA1);
    rghtIR = 1'b0;
    heading = 12'h3F0;
    tick();

    cntr_pulse();
    cntr_pulse();
    tick(2);
    hr_pulse();
    chk("mv_dn1", frwrd, 16'h2C0);
    repeat (10) hr_pulse();
    chk("mv_dn11", frwrd, 16'h040);
    chk("mv_dn_moving", moving, 16'h1);
    hr_pulse();
    chk("mv_dn0", frwrd, 16'h000);
    chk("mv_dn0_resp", send_resp, 16'h0);
    tick();
    chk("mv_done_resp", send_resp, 16'h1);
    chk("mv_done_fan", fanfare_go, 16'h0);
    chk("mv_done_moving", moving, 16'h0);
    tick();
    chk("mv_resp_end", send_resp, 16'h0);

    // Fanfare move, heading 0 (North), 2 squares
    heading = 12'h000;
    send_cmd(16'h3002);
    tick();
    chk("fan_err", error, 16'h000);
    hr_pulse();
    hr_pulse();
    hr_pulse();
    chk("fan_ramp", frwrd, 16'h040);
    cmd = 16'h4000;              // busy: must be ignored
    cmd_rdy = 1'b1;
    #1;
    chk("busy_no_clr", clr_cmd_rdy, 16'h0);
    tick();
    cmd_rdy = 1'b0;
    chk("busy_no_tour", tour_go, 16'h0);
    cntr_pulse();
    cntr_pulse();
    cntr_pulse();
    hr_pulse();
    chk("fan_3strips_up", frwrd, 16'h060);
    cntr_pulse();
    tick(2);
    hr_pulse();
    chk("fan_dn", frwrd, 16'h020);
    hr_pulse();
    chk("fan_clamp", frwrd, 16'h000);
    tick();
    chk("fan_resp", send_resp, 16'h1);
    chk("fan_go", fanfare_go, 16'h1);
    tick();
    chk("fan_go_end", {send_resp, fanfare_go}, 16'h0);

    // Unknown opcode
    send_cmd(16'h7000);
    chk("unk_pulses", {strt_cal, tour_go, moving}, 16'h0);
    tick();
    chk("unk_resp", send_resp, 16'h0);

    // Zero squares: RAMP_UP exits immediately
    send_cmd(16'h2000);
    tick();
    hr_pulse();
    tick();
    chk("sq0_wait", send_resp, 16'h0);
    tick();
    chk("sq0_resp", send_resp, 16'h1);
    chk("sq0_moving", moving, 16'h0);
    tick();

    // Reset mid-move
    send_cmd(16'h2001);
    tick();
    hr_pulse();
    hr_pulse();
    chk("rst_mv_frwrd", frwrd, 16'h020);
    lftIR = 1'b1;
    tick();
    chk("rst_mv_err", error, 16'h05F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_frwrd", frwrd, 16'h0);
    chk("arst_moving", moving, 16'h0);
    chk("arst_error", error, 16'h0);
    lftIR = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(16'h4000);
    chk("tour_go", tour_go, 16'h1);
    chk("tour_only", {moving, strt_cal, send_resp, fanfare_go}, 16'h0);
    tick();
    chk("tour_go_end", tour_go, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
